fp_decode_seq: RTL and testbench

Sequential floating-point-to-linear decoder that sits directly downstream of the 13-bit linear-to-floating-point converter. It consumes the converter's {S, E[2:0], F[4:0]} triple over a valid/ready handshake and reconstructs the 13-bit two's complement value D = (−1)^S · F · 2^E. By default it uses an iterative one-bit-per-cycle shifter; a compile-time option selects a single-cycle barrel shift instead. Its output feeds the linear-domain bench checker and downstream sinks through a second valid/ready handshake.

---
 rtl/fp_decode_seq.sv | 131 +++++++++++++
 tb/tb_fp_decode_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp_decode_seq.sv
// Purpose: rebuilds the 13-bit two's complement value D = (-1)^S * F * 2^E from an {S,E,F} float triple.
// Latency: iterative shifter gives out_valid E+1 edges after accept; FPDEC_ONECYCLE_EN gives it on the accept edge.
// Backpressure: one triple in flight; in_ready is low until the D result is taken with out_valid && out_ready.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake for the triple S (1b), E (3b), F (5b)
//   out_valid / out_ready downstream handshake for D (13b two's complement)
//   busy                 high while a triple is being shifted or waiting for downstream
// Compile-time option: define FPDEC_ONECYCLE_EN for a single-cycle barrel shift instead of the
// one-bit-per-cycle shifter. D values are identical in both builds.

module fp_decode_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [4:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] D,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [12:0] d_q, d_d;
  logic        accept;

`ifdef FPDEC_ONECYCLE_EN
  logic [12:0] shifted;
`else
  logic        s_q, s_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [12:0] mag_q, mag_d;
`endif

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
`ifdef FPDEC_ONECYCLE_EN
    // Largest magnitude is 31<<7 = 0x0F80, so the 13-bit shift never overflows.
    shifted     = {8'b0, F} << E;
`else
    s_d         = s_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef FPDEC_ONECYCLE_EN
          d_d         = S ? (~shifted + 13'd1) : shifted;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`else
          s_d     = S;
          cnt_d   = E;
          mag_d   = {8'b0, F};
          state_d = ST_SHIFT;
`endif
        end
      end

`ifndef FPDEC_ONECYCLE_EN
      ST_SHIFT: begin
        if (cnt_q != 3'd0) begin
          mag_d = {mag_q[11:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Negating zero wraps back to zero, so S=1,F=0 yields D=0.
          d_d         = s_q ? (~mag_q + 13'd1) : mag_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      d_q         <= 13'd0;
`ifndef FPDEC_ONECYCLE_EN
      s_q         <= 1'b0;
      cnt_q       <= 3'd0;
      mag_q       <= 13'd0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
`ifndef FPDEC_ONECYCLE_EN
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_decode_seq.sv
// Directed and randomized checks of fp_decode_seq against an arithmetic model of
// D = (-1)^S * F * 2^E reduced to 13 bits.

module tb_fp_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [4:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] D;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp_decode_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference: signed integer product, truncated to 13 bits.
  function automatic logic [12:0] model(input int s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s != 0) v = -v;
    return v[12:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one triple, wait for the result, stall 'stall' cycles, then take it.
  task automatic run_txn(input int s, input int e, input int f, input int stall);
    int          cycles;
    int          exp_lat;
    logic [12:0] exp_d;
    exp_d = model(s, e, f);
`ifdef FPDEC_ONECYCLE_EN
    exp_lat = 0;
`else
    exp_lat = e + 1;
`endif
    out_ready = 1'b0;
    S = s[0]; E = e[2:0]; F = f[4:0];
    in_valid = 1'b1;
    chk("pre_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs: they must only matter on the accept edge.
    S = ~S; E = 3'($urandom); F = 5'($urandom);
    chk("busy_after_accept", busy, 1'b1);
    chk("in_ready_after_accept", in_ready, 1'b0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("latency", 16'(cycles), 16'(exp_lat));
    chk("d_value", D, exp_d);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_d", D, exp_d);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_busy", busy, 1'b0);
    chk("post_hs_d_held", D, exp_d);
  endtask

  initial begin
    int cycles;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    S = 1'b0; E = 3'd0; F = 5'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_d", D, 13'h0000);
    chk("rst_busy", busy, 1'b0);
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Directed cases from the plan.
    run_txn(0, 0, 5, 0);
    chk("dir_5", D, 13'h0005);
    run_txn(0, 7, 31, 0);
    chk("dir_3968", D, 13'h0F80);
    run_txn(1, 3, 17, 1);
    chk("dir_m136", D, 13'h1F78);
    run_txn(1, 4, 0, 2);
    chk("dir_negzero", D, 13'h0000);

    // Backpressure: result 36 held while a second triple waits upstream.
    run_txn(0, 2, 9, 0);
    S = 1'b0; E = 3'd2; F = 5'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b1; S = 1'b1; E = 3'd1; F = 5'd1;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("bp_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_d", D, 13'h0024);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_in_ready_after_hs", in_ready, 1'b1);
    chk("bp_d_after_hs", D, 13'h0024);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accepted", busy, 1'b1);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("bp_second_d", D, 13'h1FFE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_second_done", in_ready, 1'b1);

    // Reset in the middle of shifting: the triple is discarded.
    S = 1'b0; E = 3'd6; F = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_d", D, 13'h0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("mid_rst_no_output", 16'(seen), 16'd0);

    // Exhaustive sweep with random stalls.
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 8; e++)
        for (int f = 0; f < 32; f++)
          run_txn(s, e, f, int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
